// File: rtl/bubble_buffer_ng_pkg.sv
// Shared constants, access-type enum and channel-index width helper for the bubble output buffer.
package bubble_pkg;

  localparam logic [2:0] ACC_BOOT = 3'b110;
  localparam logic [2:0] ACC_USER = 3'b111;

  typedef enum logic [2:0] {
    ACCT_IDLE = 3'b000,
    ACCT_BOOT = ACC_BOOT,
    ACCT_USER = ACC_USER
  } acctype_t;

  // Only 2 and 4 channels are legal, so the index width is 1 or 2.
  function automatic int clog2_ch(input int ch);
    return (ch > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/bubble_buffer_ng_if.sv
// Loader write bus, replay control and channel data of the bubble output buffer.
interface bubble_buffer_ng_if #(
  parameter int CH = 2,
  parameter int AW = 13,
  parameter int CW = 13
);
  import bubble_pkg::*;

  localparam int WA = AW + clog2_ch(CH);

  logic [2:0]    ACCTYPE;
  logic [CW-1:0] BOUTCYCLENUM;
  logic [1:0]    BOUTTICKS;
  logic [WA-1:0] BUFWRADDR;
  logic          BUFWRSTB;
  logic          BUFWRDATA;
  logic          WRCLR;
  logic [CH-1:0] DOUT;
  logic          RDVALID;
  logic [WA-1:0] WRCNT;

  modport master (
    output ACCTYPE, BOUTCYCLENUM, BOUTTICKS, BUFWRADDR, BUFWRSTB, BUFWRDATA, WRCLR,
    input  DOUT, RDVALID, WRCNT
  );

  modport slave (
    input  ACCTYPE, BOUTCYCLENUM, BOUTTICKS, BUFWRADDR, BUFWRSTB, BUFWRDATA, WRCLR,
    output DOUT, RDVALID, WRCNT
  );

endinterface

// File: rtl/bubble_buf_bank.sv
// One channel of bubble map storage: 1-bit simple dual-port RAM, synchronous read-before-write.
module bubble_buf_bank #(
  parameter int AW = 13
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem_q [2**AW];
  logic rdata_q;

  // Contents are deliberately not reset; a same-address read sees the pre-write bit.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bubble_buffer_ng.sv
// Bubble map buffer: bit-serial loader writes, CH-wide replay on each rising read tick.
// Define BUBBLE_BUF_TICKSYNC_EN to add a 2-flop synchroniser on BOUTTICKS (latency 4 instead of 2).
module bubble_buffer_ng #(
  parameter int CH       = 2,
  parameter int AW       = 13,
  parameter int CW       = 13,
  parameter int PAGE_LSB = 10
) (
  input  logic              MCLK,
  input  logic              RST,
  bubble_buffer_ng_if.slave bus
);
  import bubble_pkg::*;

  localparam int LCH = clog2_ch(CH);
  localparam int WA  = AW + LCH;

  logic          tick_s;
  logic          tick_prev_q, tick_prev_d;
  logic          rise;
  logic [AW-1:0] boot_addr, user_addr, rd_addr;
  logic          acc_active, rd_en;
  logic          pend_q, pend_d;
  logic          idle_q, idle_d;
  logic          rdvalid_q, rdvalid_d;
  logic [CH-1:0] dout_q, dout_d;
  logic [CH-1:0] rdata;
  logic [WA-1:0] wrcnt_q, wrcnt_d;
  logic [LCH-1:0] wr_ch;
  logic [AW-1:0] wr_addr;
  logic          unused_bits;

  assign unused_bits = ^{bus.BOUTTICKS[0], bus.BOUTCYCLENUM};

`ifdef BUBBLE_BUF_TICKSYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], bus.BOUTTICKS[1]};
  end
  assign tick_s = sync_q[1];
`else
  assign tick_s = bus.BOUTTICKS[1];
`endif

  assign rise = tick_s & ~tick_prev_q;

  if (CW >= AW) begin : g_boot_trunc
    assign boot_addr = bus.BOUTCYCLENUM[AW-1:0];
  end else begin : g_boot_ext
    assign boot_addr = {{(AW-CW){1'b0}}, bus.BOUTCYCLENUM};
  end

  // USER access is confined to the top page of the map.
  assign user_addr = {{(AW-PAGE_LSB){1'b1}}, bus.BOUTCYCLENUM[PAGE_LSB-1:0]};

  always_comb begin
    rd_addr    = boot_addr;
    acc_active = 1'b0;
    case (bus.ACCTYPE)
      ACCT_BOOT: acc_active = 1'b1;
      ACCT_USER: begin
        rd_addr    = user_addr;
        acc_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_en = rise & acc_active;

  assign wr_ch   = bus.BUFWRADDR[LCH-1:0];
  assign wr_addr = bus.BUFWRADDR[WA-1:LCH];

  for (genvar c = 0; c < CH; c++) begin : g_bank
    logic we;
    assign we = bus.BUFWRSTB && (wr_ch == LCH'(c));
    bubble_buf_bank #(.AW(AW)) u_bank (
      .clk_i   (MCLK),
      .we_i    (we),
      .waddr_i (wr_addr),
      .wdata_i (bus.BUFWRDATA),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rdata[c])
    );
  end

  always_comb begin
    tick_prev_d = tick_s;
    pend_d      = rise;
    idle_d      = ~acc_active;
    rdvalid_d   = pend_q;
    dout_d      = dout_q;
    if (pend_q) dout_d = idle_q ? '0 : rdata;
    wrcnt_d = wrcnt_q;
    if (bus.WRCLR)                       wrcnt_d = '0;
    else if (bus.BUFWRSTB && !(&wrcnt_q)) wrcnt_d = wrcnt_q + WA'(1);
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      tick_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      idle_q      <= 1'b0;
      rdvalid_q   <= 1'b0;
      dout_q      <= '0;
      wrcnt_q     <= '0;
    end else begin
      tick_prev_q <= tick_prev_d;
      pend_q      <= pend_d;
      idle_q      <= idle_d;
      rdvalid_q   <= rdvalid_d;
      dout_q      <= dout_d;
      wrcnt_q     <= wrcnt_d;
    end
  end

  assign bus.DOUT    = dout_q;
  assign bus.RDVALID = rdvalid_q;
  assign bus.WRCNT   = wrcnt_q;

endmodule

// File: tb/tb_bubble_buffer_ng.sv
// Scoreboard bench for bubble_buffer_ng: a 2-channel and a 4-channel instance against a bit-array model.
module tb_bubble_buffer_ng;
  import bubble_pkg::*;

`ifdef BUBBLE_BUF_TICKSYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [3:0] dout;
    logic [3:0] mask;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bubble_buffer_ng_if #(.CH(2), .AW(13), .CW(13)) if2 ();
  bubble_buffer_ng_if #(.CH(4), .AW(13), .CW(13)) if4 ();

  bubble_buffer_ng #(.CH(2), .AW(13), .CW(13), .PAGE_LSB(10)) dut2 (.MCLK(clk), .RST(rst), .bus(if2));
  bubble_buffer_ng #(.CH(4), .AW(13), .CW(13), .PAGE_LSB(10)) dut4 (.MCLK(clk), .RST(rst), .bus(if4));

  bit   mem   [2][4][8192];
  bit   known [2][4][8192];
  int   wcnt  [2];
  int   rdv_seen [2];
  int   rdv_before;
  exp_t q0 [$];
  exp_t q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model_read(input int d, input logic [2:0] acc, input int cn);
    exp_t e;
    int   a;
    int   nch;
    nch    = (d == 0) ? 2 : 4;
    e.dout = 4'h0;
    e.mask = 4'hF;
    e.due  = 0;
    if (acc == ACC_BOOT)      a = cn % 8192;
    else if (acc == ACC_USER) a = (8192 - 1024) + (cn % 1024);
    else return e;
    for (int c = 0; c < nch; c++) begin
      if (known[d][c][a]) e.dout[c] = mem[d][c][a];
      else                e.mask[c] = 1'b0;
    end
    return e;
  endfunction

  task automatic model_wr(input int d, input int addr, input bit v, input bit clr);
    int nch;
    int maxc;
    nch  = (d == 0) ? 2 : 4;
    maxc = (d == 0) ? 16383 : 32767;
    mem[d][addr % nch][addr / nch]   = v;
    known[d][addr % nch][addr / nch] = 1'b1;
    if (clr)               wcnt[d] = 0;
    else if (wcnt[d] < maxc) wcnt[d]++;
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drv_rd(input int d, input logic [2:0] acc, input int cn, input logic t);
    if (d == 0) begin
      if2.ACCTYPE = acc; if2.BOUTCYCLENUM = 13'(cn); if2.BOUTTICKS = {t, 1'($urandom)};
    end else begin
      if4.ACCTYPE = acc; if4.BOUTCYCLENUM = 13'(cn); if4.BOUTTICKS = {t, 1'($urandom)};
    end
  endtask

  task automatic drv_wr(input int d, input int addr, input bit v, input bit stb, input bit clr);
    if (d == 0) begin
      if2.BUFWRADDR = 14'(addr); if2.BUFWRDATA = v; if2.BUFWRSTB = stb; if2.WRCLR = clr;
    end else begin
      if4.BUFWRADDR = 15'(addr); if4.BUFWRDATA = v; if4.BUFWRSTB = stb; if4.WRCLR = clr;
    end
  endtask

  task automatic wr(input int d, input int addr, input bit v, input bit clr = 1'b0);
    drv_wr(d, addr, v, 1'b1, clr);
    model_wr(d, addr, v, clr);
    @(negedge clk);
    drv_wr(d, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Optional write lands on the same edge as the RAM read, so the expectation is taken first.
  task automatic tick(input int d, input logic [2:0] acc, input int cn,
                      input bit same_wr = 1'b0, input int waddr = 0, input bit wv = 1'b0);
    exp_t e;
    drv_rd(d, acc, cn, 1'b1);
    e     = model_read(d, acc, cn);
    e.due = cyc + LAT;
    push(d, e);
    for (int k = 0; k < LAT + 2; k++) begin
      if (same_wr && k == LAT - 2) begin
        drv_wr(d, waddr, wv, 1'b1, 1'b0);
        model_wr(d, waddr, wv, 1'b0);
      end
      @(negedge clk);
      drv_rd(d, acc, cn, 1'b0);
      drv_wr(d, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic burst(input int d, input logic [2:0] acc, input int cn, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drv_rd(d, acc, cn, 1'b1);
      e     = model_read(d, acc, cn);
      e.due = cyc + LAT;
      push(d, e);
      @(negedge clk);
      drv_rd(d, acc, cn, 1'b0);
      @(negedge clk);
    end
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic mon(input int d, input logic [3:0] act);
    exp_t e;
    rdv_seen[d]++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL rdvalid_unexpected dut%0d actual=1 required=0", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    checks++;
    if (((act ^ e.dout) & e.mask) !== 4'h0) begin
      errors++;
      $display("FAIL dout_dut%0d actual=%b required=%b mask=%b", d, act, e.dout, e.mask);
    end
    chk($sformatf("latency_dut%0d", d), cyc, e.due);
  endtask

  always @(negedge clk) begin
    if (!rst && if2.RDVALID === 1'b1) mon(0, {2'b00, if2.DOUT});
    if (!rst && if4.RDVALID === 1'b1) mon(1, if4.DOUT);
  end

  initial begin
    int d, nch, p;
    drv_rd(0, 3'b000, 0, 1'b0); drv_rd(1, 3'b000, 0, 1'b0);
    drv_wr(0, 0, 1'b0, 1'b0, 1'b0); drv_wr(1, 0, 1'b0, 1'b0, 1'b0);
    wcnt[0] = 0; wcnt[1] = 0; rdv_seen[0] = 0; rdv_seen[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_dout2", if2.DOUT, 0);
    chk("reset_rdvalid2", if2.RDVALID, 0);
    chk("reset_wrcnt2", if2.WRCNT, 0);
    chk("reset_dout4", if4.DOUT, 0);
    chk("reset_rdvalid4", if4.RDVALID, 0);
    chk("reset_wrcnt4", if4.WRCNT, 0);
    rst = 1'b0;
    @(negedge clk);

    wr(0, 'h0F86, 1'b1);
    wr(0, 'h0F87, 1'b0);
    chk("wrcnt_two", if2.WRCNT, wcnt[0]);
    tick(0, ACC_BOOT, 'h07C3);
    chk("dout_hold", if2.DOUT, 2'b01);

    // Reset while a read is in flight.
    rdv_before = rdv_seen[0];
    drv_rd(0, ACC_BOOT, 'h07C3, 1'b1);
    @(negedge clk);
    drv_rd(0, ACC_BOOT, 'h07C3, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_dout", if2.DOUT, 0);
    chk("rst_mid_rdvalid", if2.RDVALID, 0);
    wcnt[0] = 0; wcnt[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("rst_no_rdvalid", rdv_seen[0], rdv_before);
    chk("rst_wrcnt", if2.WRCNT, 0);

    for (int i = 0; i < 5; i++) wr(0, 'h0200 + i, 1'(i));
    chk("wrcnt_five", if2.WRCNT, 5);
    wr(0, 'h380B, 1'b1, 1'b1);
    chk("wrcnt_clr_strobe", if2.WRCNT, 0);
    wr(0, 'h380A, 1'b0);
    tick(0, ACC_USER, 'h1805);
    chk("user_dout", if2.DOUT, 2'b10);

    tick(0, 3'b000, 'h07C3);
    chk("idle_dout", if2.DOUT, 0);
    tick(0, ACC_BOOT, 'h07C3);

    wr(1, 'h0004, 1'b0); wr(1, 'h0005, 1'b0); wr(1, 'h0006, 1'b0); wr(1, 'h0007, 1'b1);
    tick(1, ACC_BOOT, 1);
    chk("ch4_dout", if4.DOUT, 4'b1000);

    wr(0, 'h0246, 1'b0);
    wr(0, 'h0247, 1'b1);
    tick(0, ACC_BOOT, 'h0123, 1'b1, 'h0246, 1'b1);
    chk("rbw_old", if2.DOUT, 2'b10);
    tick(0, ACC_BOOT, 'h0123);
    chk("rbw_new", if2.DOUT, 2'b11);

    burst(0, ACC_BOOT, 'h0123, 3);
    burst(1, ACC_BOOT, 1, 2);

    // Hold the strobe long enough to hit the counter ceiling.
    drv_wr(0, 'h3FFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16390; i++) begin
      model_wr(0, 'h3FFF, 1'b0, 1'b0);
      @(negedge clk);
    end
    drv_wr(0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrcnt_saturated", if2.WRCNT, 14'h3FFF);

    for (int i = 0; i < 80; i++) begin
      d   = $urandom_range(0, 1);
      nch = (d == 0) ? 2 : 4;
      p   = ($urandom_range(0, 1) != 0 ? 'h1C00 : 'h0100) + $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0, 1: wr(d, p * nch + $urandom_range(0, nch - 1), 1'($urandom));
        2:    tick(d, ACC_BOOT, p);
        default: begin
          if (p >= 'h1C00) tick(d, ACC_USER, ($urandom_range(0, 7) << 10) | (p & 'h3FF));
          else             tick(d, 3'($urandom_range(0, 5)), $urandom_range(0, 8191));
        end
      endcase
    end

    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    chk("wrcnt_final2", if2.WRCNT, wcnt[0]);
    chk("wrcnt_final4", if4.WRCNT, wcnt[1]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bubble_buffer_ng.md
Name: bubble_buffer_ng

Overview:
- Parametrised successor to the bubble data output buffer.
- Stores the emulated bubble map, written bit-serially by the loader, and replays it on CH parallel D lines, one bit per channel per bubble output tick.
- Fully synchronous to MCLK (48 MHz); tick edges are detected internally, not used as clocks.
- Supports 2-channel mode (all released titles) and 4-channel mode, both with configurable depth.

Parameters:
- CH, 2, channel count; legal values 2 or 4.
- AW, 13, per-channel address width; depth = 2^AW bits per channel.
- CW, 13, width of BOUTCYCLENUM.
- PAGE_LSB, 10, number of BOUTCYCLENUM bits used as page offset in USER access.

Ports:
- MCLK  in  1  48 MHz clock
- RST  in  1  reset, asynchronous, active-high
- ACCTYPE  in  3  access type; 3'b110 = BOOT, 3'b111 = USER, others = idle
- BOUTCYCLENUM  in  CW  bubble output cycle number
- BOUTTICKS  in  2  asynchronous control ticks; [1] = read tick
- BUFWRADDR  in  AW+log2(CH)  linear write address
- BUFWRSTB  in  1  write strobe, one MCLK cycle per bit
- BUFWRDATA  in  1  write data bit
- DOUT  out  CH  channel data, D0 = DOUT[0]
- RDVALID  out  1  one-cycle pulse when DOUT updates
- WRCNT  out  AW+log2(CH)  count of strobed writes since reset/clear, saturating
- WRCLR  in  1  synchronous clear of WRCNT

Behaviour:
- Reset values: DOUT = 0, RDVALID = 0, WRCNT = 0, tick synchroniser and edge registers = 0. RAM contents are not reset.
- Write decode:
  - Channel = BUFWRADDR[log2(CH)-1:0]; bank address = BUFWRADDR[AW+log2(CH)-1:log2(CH)].
  - Exactly one bank is written on an MCLK edge with BUFWRSTB = 1.
- WRCNT:
  - Increments on each strobe and saturates at all-ones.
  - WRCLR has priority over a simultaneous strobe; the result is 0 and the strobed write still occurs.
- Read address:
  - BOOT: BOUTCYCLENUM[AW-1:0]. Upper bits are dropped if CW > AW; zero-extended if CW < AW.
  - USER: {(AW-PAGE_LSB) ones, BOUTCYCLENUM[PAGE_LSB-1:0]}.
  - Idle: no RAM read. DOUT is forced to all-zero on the next tick, RDVALID still pulses.
- Read timing (sync enabled):
  - BOUTTICKS[1] passes a 2-flop synchroniser, then a rising-edge detector.
  - With edge 1 = first MCLK edge sampling BOUTTICKS[1] = 1, RAM read issues at edge 3 using ACCTYPE/BOUTCYCLENUM sampled at edge 3.
  - DOUT and RDVALID update at edge 4. Latency = 4 MCLK.
- DOUT holds its value between ticks. RDVALID is high for exactly 1 cycle per rising tick.
- Ticks closer than 4 MCLK apart are each processed in order; no tick is lost as long as the spacing is at least 2 cycles.
- Read/write to the same bank address on the same edge returns the old data (read-before-write).
- BOUTTICKS[0] is ignored.
- RST mid-read: the pending RDVALID is cancelled and DOUT goes to 0 immediately (asynchronous).
- CH = 4 with AW = 13: BUFWRADDR width is 15, matching the legacy 4-bit map.

Optional Feature:
- BUBBLE_BUF_TICKSYNC_EN, defined: 2-flop synchroniser on BOUTTICKS as above; latency 4.
- Not defined: BOUTTICKS is treated as MCLK-synchronous and feeds the edge detector directly; latency 2 (RAM read at edge 1, DOUT at edge 2).

Decomposition:
- Package bubble_pkg:
  - ACC_BOOT = 3'b110, ACC_USER = 3'b111
  - acctype_t enum
  - function clog2_ch
- Sub-module bubble_buf_bank: one-bit-wide simple dual-port RAM, 2^AW deep, synchronous read.
  - Instantiated CH times via generate, with the write enable decoded in the parent.

Test Plan:
- CH = 2: strobe bit 1 to BUFWRADDR 0x0F86 and bit 0 to BUFWRADDR 0x0F87 (bank addr 0x7C3). ACCTYPE = BOOT, BOUTCYCLENUM = 0x07C3, raise BOUTTICKS[1] -> 4 cycles later DOUT = 2'b01, RDVALID = 1 for one cycle.
- CH = 2 USER: write ch1 at bank addr 0x1C05. ACCTYPE = USER, BOUTCYCLENUM = 0x1805 -> read addr 0x1C05, DOUT[1] = written value.
- ACCTYPE = 3'b000, tick -> DOUT = 0, RDVALID pulses; RAM unchanged on a subsequent BOOT read.
- CH = 4, AW = 13: write 1 to BUFWRADDR 0x0007 (ch3, addr 1), BOOT read cycle 1 -> DOUT = 4'b1000.
- Write and read the same address in the same cycle -> old value returned; the next tick returns the new value.
- WRCNT: 5 strobes -> 5; WRCLR together with a strobe -> 0; assert RST during the tick pipeline -> RDVALID never asserted, DOUT = 0.
